// File: rtl/uart_tx_buffer.sv
// ---------------------------------------------------------------------------
// uart_tx_buffer
//
// Purpose:
//    Character FIFO in front of a UART transmitter. Characters are pushed in
//    by the host. A small launcher FSM pops one character at a time, presents
//    it on tx_data and pulses tx_wr, then waits for the transmitter to raise
//    and drop tx_busy before launching the next one.
//
// Ports:
//    clk       in   single clock, all state on its rising edge
//    resetn    in   asynchronous reset, active high (asserted = 1)
//    wr_en     in   push wr_data this cycle
//    wr_data   in   character to enqueue (UART_DATA_WIDTH bits)
//    flush     in   discard all queued characters and clear overflow
//    full      out  FIFO holds 2**ADDR_WIDTH entries
//    empty     out  FIFO holds 0 entries
//    level     out  current entry count (ADDR_WIDTH+1 bits)
//    overflow  out  sticky: a write was dropped while full
//    tx_data   out  character presented to the transmitter
//    tx_wr     out  one-cycle launch strobe to the transmitter
//    tx_busy   in   transmitter busy
// ---------------------------------------------------------------------------
module uart_tx_buffer #(
    parameter int ADDR_WIDTH      = 4,
    parameter int UART_DATA_WIDTH = 8,
    parameter int BUSY_TIMEOUT    = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       wr_en,
    input  logic [UART_DATA_WIDTH-1:0] wr_data,
    input  logic                       flush,
    output logic                       full,
    output logic                       empty,
    output logic [ADDR_WIDTH:0]        level,
    output logic                       overflow,
    output logic [UART_DATA_WIDTH-1:0] tx_data,
    output logic                       tx_wr,
    input  logic                       tx_busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [CW-1:0]       TIMEOUT_LAST = CW'(BUSY_TIMEOUT - 1);
    localparam logic [ADDR_WIDTH:0] LEVEL_FULL   = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              busyCnt_q, busyCnt_d;

    logic [UART_DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0]      wrPtr_q, wrPtr_d;
    logic [ADDR_WIDTH-1:0]      rdPtr_q, rdPtr_d;
    logic [ADDR_WIDTH:0]        level_q, level_d;
    logic                       full_q, full_d;
    logic                       empty_q, empty_d;
    logic                       overflow_q, overflow_d;
    logic [UART_DATA_WIDTH-1:0] txData_q, txData_d;

    logic                       push;
    logic                       pop;

    // The launcher pops only from idle, never while the transmitter is busy,
    // and never in a flush cycle (the flushed head must not be launched).
    assign pop  = (state_q == S_IDLE) && !empty_q && !tx_busy && !flush;
    assign push = wr_en && !full_q && !flush;

    // FIFO bookkeeping. Flush wins over everything. A write while full is
    // dropped and flagged even if a pop frees a slot in the same cycle.
    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        txData_d   = txData_q;
        if (flush) begin
            wrPtr_d    = '0;
            rdPtr_d    = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                wrPtr_d = wrPtr_q + ADDR_WIDTH'(1);
            end
            if (pop) begin
                rdPtr_d  = rdPtr_q + ADDR_WIDTH'(1);
                txData_d = mem_q[rdPtr_q];
            end
            if (wr_en && full_q) begin
                overflow_d = 1'b1;
            end
            case ({push, pop})
                2'b10:   level_d = level_q + (ADDR_WIDTH + 1)'(1);
                2'b01:   level_d = level_q - (ADDR_WIDTH + 1)'(1);
                default: level_d = level_q;
            endcase
        end
        full_d  = (level_d == LEVEL_FULL);
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            txData_q   <= '0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            txData_q   <= txData_d;
        end
    end

    // Storage needs no reset: the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= wr_data;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q   <= S_IDLE;
            busyCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            busyCnt_q <= busyCnt_d;
        end
    end

    // FSM next state. Flush only touches the FIFO, so a character already
    // launched always runs to completion. The wait-for-busy stage gives up
    // after BUSY_TIMEOUT cycles so a silent transmitter cannot hang us.
    always_comb begin
        state_d   = state_q;
        busyCnt_d = busyCnt_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d   = S_WAIT_BUSY;
                busyCnt_d = '0;
            end
            S_WAIT_BUSY: begin
                if (tx_busy || (busyCnt_q == TIMEOUT_LAST)) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    busyCnt_d = busyCnt_q + CW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: the strobe is decoded from state so reset drops it at once.
    always_comb begin
        tx_wr = 1'b0;
        if (state_q == S_LAUNCH) begin
            tx_wr = 1'b1;
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign tx_data  = txData_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_buffer
//
// Directed bench for uart_tx_buffer (default parameters). A simple UART
// model can hold tx_busy for 10 cycles after each launch; tx_busy can also
// be forced high or left low. Every launch strobe is logged with its data
// and the cycle it was seen in.
// ---------------------------------------------------------------------------
module tb_uart_tx_buffer;

    logic       clk;
    logic       resetn;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       flush;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_busy;

    logic       forceBusy;
    logic       modelEn;
    logic       modelBusy = 1'b0;
    int         modelCnt  = 0;
    int         cycleCnt  = 0;
    int         busyViol  = 0;
    logic [7:0] txLog[$];
    int         pulseCycle[$];

    int         total = 0;
    int         bad   = 0;
    int         base;

    uart_tx_buffer #(
        .ADDR_WIDTH      (4),
        .UART_DATA_WIDTH (8),
        .BUSY_TIMEOUT    (4)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .flush    (flush),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow),
        .tx_data  (tx_data),
        .tx_wr    (tx_wr),
        .tx_busy  (tx_busy)
    );

    assign tx_busy = forceBusy | modelBusy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch logger and UART busy model
    always @(negedge clk) begin
        cycleCnt <= cycleCnt + 1;
        if (tx_wr) begin
            txLog.push_back(tx_data);
            pulseCycle.push_back(cycleCnt);
            if (tx_busy) begin
                busyViol <= busyViol + 1;
            end
        end
        if (modelEn && tx_wr) begin
            modelBusy <= 1'b1;
            modelCnt  <= 10;
        end else if (modelCnt > 0) begin
            modelCnt <= modelCnt - 1;
            if (modelCnt == 1) begin
                modelBusy <= 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs starting at a falling edge
    task automatic applyStimulus(input logic wr, input logic [7:0] data, input logic fl);
        wr_en   = wr;
        wr_data = data;
        flush   = fl;
        @(negedge clk);
        wr_en   = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic waitPulses(input int count, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (txLog.size() >= count) break;
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] logAt(input int idx);
        if (idx < txLog.size()) return 32'(txLog[idx]);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] cycleAt(input int idx);
        if (idx < pulseCycle.size()) return 32'(pulseCycle[idx]);
        return 32'hFFFF_FFFF;
    endfunction

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn    = 1'b0;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        flush     = 1'b0;
        forceBusy = 1'b0;
        modelEn   = 1'b0;
        #1 resetn = 1'b1;
        #2;
        $display("[TB] reset values");
        checkOutput("rst_level",    32'(level),    32'd0);
        checkOutput("rst_empty",    32'(empty),    32'd1);
        checkOutput("rst_full",     32'(full),     32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_tx_wr",    32'(tx_wr),    32'd0);
        checkOutput("rst_tx_data",  32'(tx_data),  32'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);

        $display("[TB] three characters through a 10-cycle busy model");
        base    = txLog.size();
        modelEn = 1'b1;
        applyStimulus(1'b1, 8'h41, 1'b0);
        applyStimulus(1'b1, 8'h42, 1'b0);
        applyStimulus(1'b1, 8'h43, 1'b0);
        waitPulses(base + 3, 200);
        repeat (30) @(negedge clk);
        checkOutput("seq_pulses", 32'(txLog.size()), 32'(base + 3));
        checkOutput("seq_char0",  logAt(base),       32'h41);
        checkOutput("seq_char1",  logAt(base + 1),   32'h42);
        checkOutput("seq_char2",  logAt(base + 2),   32'h43);
        checkOutput("seq_busy_violations", 32'(busyViol), 32'd0);
        checkOutput("seq_level",  32'(level),        32'd0);
        checkOutput("seq_empty",  32'(empty),        32'd1);
        modelEn = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] busy never rises: timeout path");
        base = txLog.size();
        applyStimulus(1'b1, 8'h55, 1'b0);
        repeat (20) @(negedge clk);
        checkOutput("to_pulses",  32'(txLog.size()), 32'(base + 1));
        checkOutput("to_char",    logAt(base),       32'h55);
        checkOutput("to_tx_data_hold", 32'(tx_data), 32'h55);
        checkOutput("to_tx_wr_idle",   32'(tx_wr),   32'd0);
        applyStimulus(1'b1, 8'h66, 1'b0);
        applyStimulus(1'b1, 8'h77, 1'b0);
        waitPulses(base + 3, 50);
        repeat (20) @(negedge clk);
        checkOutput("to_char_b",  logAt(base + 1),   32'h66);
        checkOutput("to_char_c",  logAt(base + 2),   32'h77);
        checkOutput("to_launch_gap", cycleAt(base + 2) - cycleAt(base + 1), 32'd7);
        checkOutput("to_empty",   32'(empty),        32'd1);

        $display("[TB] fill to full with busy held high");
        base      = txLog.size();
        forceBusy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(8'h80 + i), 1'b0);
        end
        checkOutput("fill_level",    32'(level),    32'd16);
        checkOutput("fill_full",     32'(full),     32'd1);
        checkOutput("fill_empty",    32'(empty),    32'd0);
        checkOutput("fill_overflow", 32'(overflow), 32'd0);
        applyStimulus(1'b1, 8'hEE, 1'b0);
        checkOutput("ovf_level",     32'(level),    32'd16);
        checkOutput("ovf_full",      32'(full),     32'd1);
        checkOutput("ovf_overflow",  32'(overflow), 32'd1);

        $display("[TB] push and pop together while full");
        forceBusy = 1'b0;
        applyStimulus(1'b1, 8'hDD, 1'b0);
        forceBusy = 1'b1;
        checkOutput("pp_full_level",    32'(level),    32'd15);
        checkOutput("pp_full_overflow", 32'(overflow), 32'd1);
        checkOutput("pp_full_tx_data",  32'(tx_data),  32'h80);
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("fl1_level",    32'(level),    32'd0);
        checkOutput("fl1_empty",    32'(empty),    32'd1);
        checkOutput("fl1_overflow", 32'(overflow), 32'd0);

        $display("[TB] push and pop together at level 5");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'(8'h21 + i), 1'b0);
        end
        checkOutput("pp5_level_pre", 32'(level), 32'd5);
        forceBusy = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("pp5_level_idle", 32'(level), 32'd5);
        applyStimulus(1'b1, 8'h26, 1'b0);
        forceBusy = 1'b1;
        checkOutput("pp5_level",    32'(level),    32'd5);
        checkOutput("pp5_overflow", 32'(overflow), 32'd0);
        checkOutput("pp5_tx_data",  32'(tx_data),  32'h21);
        repeat (3) @(negedge clk);
        checkOutput("pp_pulses",    32'(txLog.size()), 32'(base + 2));
        checkOutput("pp_char0",     logAt(base),       32'h80);
        checkOutput("pp_char1",     logAt(base + 1),   32'h21);

        $display("[TB] flush while waiting for the transmitter to finish");
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b1, 8'h31, 1'b0);
        applyStimulus(1'b1, 8'h32, 1'b0);
        applyStimulus(1'b1, 8'h33, 1'b0);
        checkOutput("fl2_level_pre", 32'(level), 32'd3);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("fl2_level",    32'(level),    32'd0);
        checkOutput("fl2_empty",    32'(empty),    32'd1);
        checkOutput("fl2_overflow", 32'(overflow), 32'd0);
        checkOutput("fl2_tx_data",  32'(tx_data),  32'h21);
        forceBusy = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("fl2_no_more_pulses", 32'(txLog.size()), 32'(base + 2));
        checkOutput("fl2_empty_after",    32'(empty),        32'd1);

        $display("[TB] reset in the middle of a transmission");
        base = txLog.size();
        applyStimulus(1'b1, 8'h61, 1'b0);
        applyStimulus(1'b1, 8'h62, 1'b0);
        applyStimulus(1'b1, 8'h63, 1'b0);
        checkOutput("mr_level_pre",   32'(level),   32'd2);
        checkOutput("mr_tx_data_pre", 32'(tx_data), 32'h61);
        resetn = 1'b1;
        #1;
        checkOutput("mr_level",    32'(level),    32'd0);
        checkOutput("mr_empty",    32'(empty),    32'd1);
        checkOutput("mr_full",     32'(full),     32'd0);
        checkOutput("mr_overflow", 32'(overflow), 32'd0);
        checkOutput("mr_tx_wr",    32'(tx_wr),    32'd0);
        checkOutput("mr_tx_data",  32'(tx_data),  32'd0);
        @(negedge clk);
        resetn = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("mr_pulses",   32'(txLog.size()), 32'(base + 1));
        checkOutput("mr_char",     logAt(base),       32'h61);
        checkOutput("mr_empty_after", 32'(empty),     32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
